// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven attack/decay/sustain/release amplitude contour, one level step per sample tick.
// Optional ADSR_EXP_RELEASE_EN selects an exponential-style release tail instead of a linear ramp.
module adsr_envelope #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             gate,
    input  logic [WIDTH-1:0] attack_rate,
    input  logic [WIDTH-1:0] decay_rate,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0] release_rate,
    output logic [WIDTH-1:0] env_out,
    output logic [2:0]       stage,
    output logic             active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } stage_t;

    localparam logic [WIDTH-1:0] FULL = '1;

    stage_t           state, state_n;
    logic [WIDTH-1:0] env, env_n;
    logic             gate_q;
    logic             active_q;
    logic             rise, fall;
    logic [WIDTH:0]   att_sum;
    logic [WIDTH:0]   dec_diff;
    logic [WIDTH-1:0] rel_step;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    // One extra bit so overflow/underflow is visible instead of wrapping.
    assign att_sum  = {1'b0, env} + {1'b0, attack_rate};
    assign dec_diff = {1'b0, env} - {1'b0, decay_rate};

`ifdef ADSR_EXP_RELEASE_EN
    logic [WIDTH-1:0] rel_shifted;
    logic             unused_rel_hi;
    assign rel_shifted   = env >> release_rate[3:0];
    assign rel_step      = (rel_shifted == '0) ? WIDTH'(1) : rel_shifted;
    assign unused_rel_hi = ^release_rate[WIDTH-1:4];
`else
    assign rel_step = release_rate;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            env      <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_n;
            env      <= env_n;
            gate_q   <= gate;
            active_q <= (state_n != IDLE);
        end
    end

    // Gate edges take priority over the tick and freeze the level for that cycle.
    always_comb begin
        state_n = state;
        env_n   = env;
        if (rise) begin
            state_n = ATTACK;
        end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
            state_n = RELEASE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    env_n = '0;
                end
                ATTACK: begin
                    if (att_sum >= {1'b0, FULL} || attack_rate == '0) begin
                        env_n   = FULL;
                        state_n = DECAY;
                    end else begin
                        env_n = att_sum[WIDTH-1:0];
                    end
                end
                DECAY: begin
                    if (decay_rate == '0 || env < sustain_level ||
                        dec_diff[WIDTH] || dec_diff[WIDTH-1:0] <= sustain_level) begin
                        env_n   = sustain_level;
                        state_n = SUSTAIN;
                    end else begin
                        env_n = dec_diff[WIDTH-1:0];
                    end
                end
                SUSTAIN: begin
                    env_n = sustain_level;
                end
                RELEASE: begin
                    if (rel_step == '0 || env <= rel_step) begin
                        env_n   = '0;
                        state_n = IDLE;
                    end else begin
                        env_n = env - rel_step;
                    end
                end
                default: begin
                    env_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        env_out = env;
        stage   = state;
        active  = active_q;
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope; expectations are hand-computed for whichever release build is compiled.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        gate;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [15:0] sustain_level;
    logic [15:0] release_rate;
    logic [15:0] env_out;
    logic [2:0]  stage;
    logic        active;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ADSR_EXP_RELEASE_EN
    localparam logic [15:0] REL_START = 16'h1000;
    localparam logic [15:0] REL_R1    = 16'd4;
    localparam logic [15:0] REL_R2    = 16'd1;
`else
    localparam logic [15:0] REL_START = 16'h4000;
    localparam logic [15:0] REL_R1    = 16'h2000;
    localparam logic [15:0] REL_R2    = 16'h3000;
`endif

    adsr_envelope #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env_out       (env_out),
        .stage         (stage),
        .active        (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic [15:0] e, input logic [2:0] s, input logic a);
        chk({tag, "_env"}, 32'(env_out), 32'(e));
        chk({tag, "_stage"}, 32'(stage), 32'(s));
        chk({tag, "_active"}, 32'(active), 32'(a));
    endtask

    initial begin
        logic [15:0] prev;
        rst = 1'b1; tick = 1'b0; gate = 1'b0;
        attack_rate = 16'h1000; decay_rate = 16'h0800;
        sustain_level = 16'h4000; release_rate = REL_R1;
        cyc(0); cyc(0);
        chk3("reset", 16'h0000, 3'd0, 1'b0);

        // Attack from 0 in 0x1000 steps, tick every 4th clock.
        rst = 1'b0;
        gate = 1'b1;
        cyc(0);
        chk3("gate_rise", 16'h0000, 3'd1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            repeat (3) cyc(0);
            cyc(1);
            chk("attack_env", 32'(env_out), (k < 16) ? 32'(k * 32'h1000) : 32'h0000_FFFF);
            chk("attack_stage", 32'(stage), (k < 16) ? 32'd1 : 32'd2);
        end

        // Decay 0xFFFF -> 0x4000 lands on sustain at tick 24.
        for (int k = 1; k <= 24; k++) begin
            cyc(1);
            chk("decay_env", 32'(env_out), (k < 24) ? (32'h0000_FFFF - k * 32'h800) : 32'h0000_4000);
            chk("decay_stage", 32'(stage), (k < 24) ? 32'd2 : 32'd3);
        end

        sustain_level = 16'h5000;
        cyc(1);
        chk3("sustain_track", 16'h5000, 3'd3, 1'b1);

        sustain_level = REL_START;
        cyc(1);
        chk3("sustain_pre_rel", REL_START, 3'd3, 1'b1);

        // Fall coincident with tick: edge wins, level held.
        gate = 1'b0;
        cyc(1);
        chk3("fall_tick", REL_START, 3'd4, 1'b1);
`ifdef ADSR_EXP_RELEASE_EN
        cyc(1);
        chk3("exp_rel1", 16'h0F00, 3'd4, 1'b1);
        cyc(1);
        chk3("exp_rel2", 16'h0E10, 3'd4, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (stage == 3'd0) break;
            prev = env_out;
            cyc(1);
            chk("exp_monotone", 32'(env_out < prev), 32'd1);
        end
        chk3("exp_rel_end", 16'h0000, 3'd0, 1'b0);
`else
        cyc(1);
        chk3("lin_rel1", 16'h2000, 3'd4, 1'b1);
        cyc(1);
        chk3("lin_rel2", 16'h0000, 3'd0, 1'b0);
`endif
        cyc(1);
        chk3("idle_stays", 16'h0000, 3'd0, 1'b0);

        // Fast attack, instant decay to 0x6000, then release to 0x3000 and retrigger.
        attack_rate = 16'h3000; decay_rate = 16'h0000;
        sustain_level = 16'h6000; release_rate = REL_R2;
        gate = 1'b1;
        cyc(0);
        chk3("rt_rise", 16'h0000, 3'd1, 1'b1);
        repeat (5) cyc(1);
        chk3("rt_attack5", 16'hF000, 3'd1, 1'b1);
        cyc(1);
        chk3("rt_attack_sat", 16'hFFFF, 3'd2, 1'b1);
        cyc(1);
        chk3("rt_decay0", 16'h6000, 3'd3, 1'b1);
        gate = 1'b0;
        cyc(0);
        chk3("rt_fall", 16'h6000, 3'd4, 1'b1);
        cyc(1);
        chk3("rt_rel", 16'h3000, 3'd4, 1'b1);
        gate = 1'b1;
        cyc(1);
        chk3("rt_retrig", 16'h3000, 3'd1, 1'b1);
        cyc(1);
        chk3("rt_resume", 16'h6000, 3'd1, 1'b1);

        // Reach sustain at 0x8000, then reset mid-envelope with gate held high.
        sustain_level = 16'h8000;
        repeat (5) cyc(1);
        chk3("pre_rst_sus", 16'h8000, 3'd3, 1'b1);
        rst = 1'b1;
        cyc(1);
        chk3("mid_rst", 16'h0000, 3'd0, 1'b0);
        rst = 1'b0;
        cyc(0);
        chk3("post_rst_rise", 16'h0000, 3'd1, 1'b1);

        // attack_rate of zero saturates immediately.
        attack_rate = 16'h0000;
        cyc(1);
        chk3("attack_zero", 16'hFFFF, 3'd2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
